alu_issue_arbiter: RTL

Two-requester issue controller for the 64-bit pipelined ALU (ops ADD/SUB/MUL/NAND/AND/OR/PASSB, opcodes 0–6).
- Accepts operations from two requesters over valid/ready handshakes and arbitrates round-robin.
- Drives the ALU's registered operand ports and tracks in-flight ops with a tag pipeline.
- Routes each result, with carry/zero/sign flags, back to the requester that issued it.
- Sits directly between the ALU and its two client engines.
- Supports a drain/halt sequence so the ALU can be quiesced.

---
 rtl/alu_issue_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue controller for two requesters that share the pipelined ALU.
// Optional build macro ALU_ARB_PERF_EN adds saturating per-requester grant counters.
`timescale 1ns/1ps
module alu_issue_arbiter #(
    parameter int W       = 64,
    parameter int ALU_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_opcode,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_opcode,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [3:0]   alu_opcode,
    output logic [W-1:0] alu_input1,
    output logic [W-1:0] alu_input2,
    output logic [4:0]   alu_shift,
    input  logic [W-1:0] alu_result,
    input  logic         alu_carry,
    output logic         resp0_valid,
    output logic         resp1_valid,
    output logic [W-1:0] resp_result,
    output logic         resp_carry,
    output logic         resp_zero,
    output logic         resp_sign,
    output logic         resp_err,
    input  logic         drain,
    output logic         idle
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]  perf_grant0,
    output logic [15:0]  perf_grant1
`endif
);

    localparam int DEPTH = ALU_LAT + 1;

    typedef enum logic [1:0] {RUN, DRAINING, HALTED} state_t;

    typedef struct packed {
        logic v;
        logic id;
        logic err;
        logic isarith;
    } tag_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last;
    tag_t         r_tag [DEPTH];
    logic [3:0]   r_alu_opcode;
    logic [W-1:0] r_alu_in1;
    logic [W-1:0] r_alu_in2;

    logic         w_run;
    logic         w_grant0;
    logic         w_grant1;
    logic         w_fire;
    logic [3:0]   w_op;
    tag_t         w_tag_in;
    tag_t         w_tag_out;
    logic         w_drained;

    // r_last==1 means req1 won most recently, so req0 takes the next contested grant.
    assign w_run    = (r_state == RUN) && !rst;
    assign w_grant0 = w_run && req0_valid && (!req1_valid || r_last);
    assign w_grant1 = w_run && req1_valid && (!req0_valid || !r_last);
    assign w_fire   = w_grant0 || w_grant1;
    assign w_op     = w_grant1 ? req1_opcode : req0_opcode;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_tag_in = '0;
        if (w_fire) begin
            w_tag_in.v       = 1'b1;
            w_tag_in.id      = w_grant1;
            w_tag_in.err     = (w_op > 4'd6);
            w_tag_in.isarith = (w_op <= 4'd1);
        end
    end

    // The last stage is retiring this cycle, so only the earlier stages count as still in flight.
    always_comb begin
        w_drained = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (r_tag[i].v) begin
                w_drained = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:      if (drain) w_state_nxt = DRAINING;
            DRAINING: begin
                if (!drain)         w_state_nxt = RUN;
                else if (w_drained) w_state_nxt = HALTED;
            end
            HALTED:   if (!drain) w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last       <= 1'b1;
            r_alu_opcode <= 4'hF;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            // NOTE: the tag pipe is reset entry by entry; a surviving v bit would emit a phantom response.
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_fire) begin
                r_last       <= w_grant1;
                r_alu_opcode <= w_op;
                r_alu_in1    <= w_grant1 ? req1_a : req0_a;
                r_alu_in2    <= w_grant1 ? req1_b : req0_b;
            end else begin
                r_alu_opcode <= 4'hF;
            end
        end
    end

    assign alu_opcode = r_alu_opcode;
    assign alu_input1 = r_alu_in1;
    assign alu_input2 = r_alu_in2;
    assign alu_shift  = 5'd0;

    // The ALU only refreshes carry on ADD/SUB, so it is masked for every other op.
    assign w_tag_out   = r_tag[DEPTH-1];
    assign resp0_valid = w_tag_out.v && !w_tag_out.id;
    assign resp1_valid = w_tag_out.v && w_tag_out.id;
    assign resp_result = w_tag_out.v ? alu_result : '0;
    assign resp_carry  = w_tag_out.v && w_tag_out.isarith && alu_carry;
    assign resp_zero   = w_tag_out.v && (alu_result == '0);
    assign resp_sign   = w_tag_out.v && alu_result[W-1];
    assign resp_err    = w_tag_out.v && w_tag_out.err;

    assign idle = (r_state == HALTED);

`ifdef ALU_ARB_PERF_EN
    logic [15:0] r_perf0;
    logic [15:0] r_perf1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf0 <= '0;
            r_perf1 <= '0;
        end else begin
            if (w_grant0 && (r_perf0 != 16'hFFFF)) r_perf0 <= r_perf0 + 16'd1;
            if (w_grant1 && (r_perf1 != 16'hFFFF)) r_perf1 <= r_perf1 + 16'd1;
        end
    end

    assign perf_grant0 = r_perf0;
    assign perf_grant1 = r_perf1;
`endif

endmodule
